// File: rtl/systolic_pkg.sv
`default_nettype none
// ---- systolic_pkg : drain FSM states, default completion signature, drain index helpers. Rev 1.0 ----
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SIGN  = 2'd2,
    S_DONE  = 2'd3
  } drain_state_t;

  localparam logic [63:0] DEFAULT_SIGNATURE = 64'hF;

  // Row-major drain order: linear index -> (row, col) of the PE grid.
  function automatic int unsigned idx_row(input int unsigned idx, input int unsigned cols);
    return idx / cols;
  endfunction

  function automatic int unsigned idx_col(input int unsigned idx, input int unsigned cols);
    return idx % cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ---- systolic_pe : one output-stationary MAC cell with west->east / north->south forwarding. Rev 1.0 ----
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] north,
  input  logic [DATA_W-1:0] west,
  output logic [DATA_W-1:0] south,
  output logic [DATA_W-1:0] east,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, north} * {{DATA_W{1'b0}}, west};

  // Operands keep moving even when accumulation is gated off.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      south <= '0;
      east  <= '0;
      acc   <= '0;
    end else begin
      south <= north;
      east  <= west;
      if (acc_en) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_array_mxn.sv
`default_nettype none
// ---- systolic_array_mxn : ROWS x COLS output-stationary MAC array with row-major result drain. Rev 1.0 ----
module systolic_array_mxn
  import systolic_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int DOUT_W = 64,
  parameter int ADDR_W = 11,
  parameter logic [DOUT_W-1:0] SIGNATURE = DOUT_W'(DEFAULT_SIGNATURE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst_flush,
  input  logic                     valid,
  input  logic [ROWS*DATA_W-1:0]   west_in,
  input  logic [COLS*DATA_W-1:0]   north_in,
  input  logic                     drain_start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     wr_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DOUT_W-1:0]        wr_din,
  output logic                     busy,
  output logic                     drain_done
);

  localparam int NPE   = ROWS * COLS;
  localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int BUS_W = NPE * ACC_W;
  localparam int SEL_W = (BUS_W > 1) ? $clog2(BUS_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPE - 1);

  logic [DATA_W-1:0] hfwd [ROWS][COLS+1];
  logic [DATA_W-1:0] vfwd [ROWS+1][COLS];
  logic [BUS_W-1:0]  acc_bus;
  logic              acc_en;

  drain_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, read_idx;
  logic [ADDR_W-1:0] base_q, base_d, wr_addr_d;
  logic [DOUT_W-1:0] wr_din_d;
  logic              wr_en_d, done_d;
  logic [SEL_W-1:0]  rd_sel;
  logic [ACC_W-1:0]  rd_acc;

  assign acc_en = valid && (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);

  genvar r, c;
  generate
    for (c = 0; c < COLS; c++) begin : g_north
      assign vfwd[0][c] = north_in[c*DATA_W +: DATA_W];
    end
    for (r = 0; r < ROWS; r++) begin : g_row
      assign hfwd[r][0] = west_in[r*DATA_W +: DATA_W];
      for (c = 0; c < COLS; c++) begin : g_col
        systolic_pe #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W)
        ) u_pe (
          .clk    (clk),
          .rst_n  (rst_n),
          .clear  (rst_flush),
          .acc_en (acc_en),
          .north  (vfwd[r][c]),
          .west   (hfwd[r][c]),
          .south  (vfwd[r+1][c]),
          .east   (hfwd[r][c+1]),
          .acc    (acc_bus[(r*COLS+c)*ACC_W +: ACC_W])
        );
      end
    end
  endgenerate

  // Pre-fetch the word for the beat that follows the current one so outputs stay registered.
  assign read_idx = (state_q == S_DRAIN && idx_q != LAST) ? idx_q + 1'b1 : '0;

  always_comb begin
    rd_sel = SEL_W'((idx_row(32'(read_idx), COLS) * COLS + idx_col(32'(read_idx), COLS)) * ACC_W);
    rd_acc = acc_bus[rd_sel +: ACC_W];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    wr_en_d   = wr_en;
    wr_addr_d = wr_addr;
    wr_din_d  = wr_din;
    done_d    = drain_done;
    case (state_q)
      S_IDLE: begin
        if (drain_start) begin
          state_d   = S_DRAIN;
          idx_d     = '0;
          base_d    = base_addr;
          wr_en_d   = 1'b1;
          wr_addr_d = base_addr + 1'b1;
          wr_din_d  = DOUT_W'(rd_acc);
        end
      end
      S_DRAIN: begin
        if (wr_ready) begin
          if (idx_q == LAST) begin
            state_d   = S_SIGN;
            wr_addr_d = base_q;
            wr_din_d  = SIGNATURE;
          end else begin
            idx_d     = idx_q + 1'b1;
            wr_addr_d = wr_addr + 1'b1;
            wr_din_d  = DOUT_W'(rd_acc);
          end
        end
      end
      S_SIGN: begin
        if (wr_ready) begin
          state_d = S_DONE;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rst_flush) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_din     <= '0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_din     <= wr_din_d;
      drain_done <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_mxn.sv
`timescale 1ns/1ps
`default_nettype none
// ---- tb_systolic_array_mxn : directed checks of a 2x2 and an 8x8 instance of systolic_array_mxn. Rev 1.0 ----
module tb_systolic_array_mxn;

  localparam int DW  = 32;
  localparam int OW  = 64;
  localparam int ADW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_flush;

  logic              valid2, start2, ready2;
  logic [2*DW-1:0]   west2, north2;
  logic [ADW-1:0]    base2;
  logic              wr_en2, busy2, done2;
  logic [ADW-1:0]    wr_addr2;
  logic [OW-1:0]     wr_din2;

  logic              valid8, start8, ready8;
  logic [8*DW-1:0]   west8, north8;
  logic [ADW-1:0]    base8;
  logic              wr_en8, busy8, done8;
  logic [ADW-1:0]    wr_addr8;
  logic [OW-1:0]     wr_din8;

  int n_checks = 0;
  int n_pass   = 0;

  systolic_array_mxn #(.ROWS(2), .COLS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rst_flush(rst_flush), .valid(valid2),
    .west_in(west2), .north_in(north2), .drain_start(start2), .base_addr(base2),
    .wr_ready(ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_din(wr_din2),
    .busy(busy2), .drain_done(done2)
  );

  systolic_array_mxn u_dut8 (
    .clk(clk), .rst_n(rst_n), .rst_flush(rst_flush), .valid(valid8),
    .west_in(west8), .north_in(north8), .drain_start(start8), .base_addr(base8),
    .wr_ready(ready8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_din(wr_din8),
    .busy(busy8), .drain_done(done8)
  );

  typedef struct packed {
    logic [3:0][31:0] a;     // A[r][k] at a[r*2+k]
    logic [3:0][31:0] b;     // B[k][c] at b[k*2+c]
    logic [10:0]      base;
    logic [3:0][63:0] c;     // expected C row-major
  } vec2_t;

  vec2_t       vecs [4];
  int          a8 [8][8];
  int          b8 [8][8];
  logic [63:0] exp8 [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec2_t mk2(input logic [31:0] a00, a01, a10, a11,
                                input logic [31:0] b00, b01, b10, b11,
                                input logic [10:0] base,
                                input logic [63:0] c00, c01, c10, c11);
    vec2_t v;
    v.a[0] = a00; v.a[1] = a01; v.a[2] = a10; v.a[3] = a11;
    v.b[0] = b00; v.b[1] = b01; v.b[2] = b10; v.b[3] = b11;
    v.base = base;
    v.c[0] = c00; v.c[1] = c01; v.c[2] = c10; v.c[3] = c11;
    return v;
  endfunction

  task automatic flush();
    rst_flush = 1'b1;
    tick();
    rst_flush = 1'b0;
  endtask

  task automatic feed2(input vec2_t v);
    for (int t = 0; t < 4; t++) begin
      valid2 = 1'b1;
      for (int r = 0; r < 2; r++) begin
        int k;
        k = t - r;
        west2[r*DW +: DW] = (k >= 0 && k < 2) ? v.a[r*2+k] : '0;
      end
      for (int c = 0; c < 2; c++) begin
        int k;
        k = t - c;
        north2[c*DW +: DW] = (k >= 0 && k < 2) ? v.b[k*2+c] : '0;
      end
      tick();
    end
    valid2 = 1'b0; west2 = '0; north2 = '0;
    tick();
  endtask

  task automatic drain2(input string tag, input vec2_t v, input bit toggle);
    logic [ADW-1:0] ea [5];
    logic [63:0]    ed [5];
    int k, cyc;
    for (int i = 0; i < 4; i++) begin
      ea[i] = v.base + 11'(i + 1);
      ed[i] = v.c[i];
    end
    ea[4] = v.base;
    ed[4] = 64'hF;
    start2 = 1'b1; base2 = v.base; ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 40) begin
      ready2 = toggle ? (cyc % 2 == 0) : 1'b1;
      chk($sformatf("%s beat%0d wr_en", tag, k), {63'd0, wr_en2}, 64'd1);
      chk($sformatf("%s beat%0d addr", tag, k), {53'd0, wr_addr2}, {53'd0, ea[k]});
      chk($sformatf("%s beat%0d data", tag, k), wr_din2, ed[k]);
      if (ready2) k++;
      tick();
      cyc++;
    end
    ready2 = 1'b1;
    chk($sformatf("%s beat count", tag), 64'(k), 64'd5);
    chk($sformatf("%s drain_done", tag), {63'd0, done2}, 64'd1);
    chk($sformatf("%s wr_en after done", tag), {63'd0, wr_en2}, 64'd0);
    chk($sformatf("%s busy in done", tag), {63'd0, busy2}, 64'd1);
  endtask

  task automatic feed8();
    for (int t = 0; t < 22; t++) begin
      valid8 = 1'b1;
      for (int r = 0; r < 8; r++) begin
        int k;
        k = t - r;
        west8[r*DW +: DW] = (k >= 0 && k < 8) ? 32'(a8[r][k]) : '0;
      end
      for (int c = 0; c < 8; c++) begin
        int k;
        k = t - c;
        north8[c*DW +: DW] = (k >= 0 && k < 8) ? 32'(b8[k][c]) : '0;
      end
      tick();
    end
    valid8 = 1'b0; west8 = '0; north8 = '0;
    tick();
  endtask

  // gate: inject operands and a second drain_start mid-drain; abort >= 0: flush once that many beats are done.
  task automatic drain8(input string tag, input logic [ADW-1:0] base, input bit gate, input int abort);
    logic [ADW-1:0] ea;
    logic [63:0]    ed;
    int k, cyc;
    start8 = 1'b1; base8 = base; ready8 = 1'b1;
    tick();
    start8 = 1'b0;
    k = 0; cyc = 0;
    while (k < 65 && cyc < 100) begin
      if (abort >= 0 && k == abort) begin
        flush();
        chk($sformatf("%s flush wr_en", tag), {63'd0, wr_en8}, 64'd0);
        chk($sformatf("%s flush busy", tag), {63'd0, busy8}, 64'd0);
        chk($sformatf("%s flush done", tag), {63'd0, done8}, 64'd0);
        return;
      end
      if (gate && k >= 3 && k < 12) begin
        valid8 = 1'b1; west8 = {8{32'd3}}; north8 = {8{32'd3}};
        start8 = 1'b1; base8 = 11'h200;
      end else begin
        valid8 = 1'b0; west8 = '0; north8 = '0; start8 = 1'b0;
      end
      ea = (k < 64) ? base + 11'(k + 1) : base;
      ed = (k < 64) ? exp8[k] : 64'hF;
      chk($sformatf("%s beat%0d wr_en", tag, k), {63'd0, wr_en8}, 64'd1);
      chk($sformatf("%s beat%0d addr", tag, k), {53'd0, wr_addr8}, {53'd0, ea});
      chk($sformatf("%s beat%0d data", tag, k), wr_din8, ed);
      k++;
      tick();
      cyc++;
    end
    valid8 = 1'b0; west8 = '0; north8 = '0; start8 = 1'b0;
    chk($sformatf("%s beat count", tag), 64'(k), 64'd65);
    chk($sformatf("%s drain_done", tag), {63'd0, done8}, 64'd1);
    chk($sformatf("%s busy in done", tag), {63'd0, busy8}, 64'd1);
    if (gate) begin
      start8 = 1'b1; base8 = 11'h300;
      tick();
      start8 = 1'b0;
      tick();
      chk($sformatf("%s done held", tag), {63'd0, done8}, 64'd1);
      chk($sformatf("%s no restart", tag), {63'd0, wr_en8}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk2(1, 2, 3, 4,   5, 6, 7, 8,   11'h010,  19, 22, 43, 50);
    vecs[1] = mk2(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,
                  32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0,
                  11'h7FF,  64'hFFFFFFFC00000002, 0, 0, 0);
    vecs[2] = mk2(2, 0, 0, 2,   10, 20, 30, 40,  11'h100,  20, 40, 60, 80);
    vecs[3] = mk2(7, 1, 0, 5,   3, 2, 4, 9,      11'h3FC,  25, 23, 20, 45);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a8[r][c] = (r == c) ? 1 : 0;
        b8[r][c] = r * 100 + c * 7 + 1;
      end

    rst_n = 1'b0; rst_flush = 1'b0;
    valid2 = 0; start2 = 0; ready2 = 1; west2 = '0; north2 = '0; base2 = '0;
    valid8 = 0; start8 = 0; ready8 = 1; west8 = '0; north8 = '0; base8 = '0;
    tick();
    tick();
    chk("reset wr_en2", {63'd0, wr_en2}, 64'd0);
    chk("reset busy2", {63'd0, busy2}, 64'd0);
    chk("reset done2", {63'd0, done2}, 64'd0);
    chk("reset wr_din2", wr_din2, 64'd0);
    chk("reset wr_en8", {63'd0, wr_en8}, 64'd0);
    chk("reset busy8", {63'd0, busy8}, 64'd0);
    chk("reset done8", {63'd0, done8}, 64'd0);
    chk("reset wr_addr8", {53'd0, wr_addr8}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 64; i++) exp8[i] = 64'd0;
    drain8("rst8", 11'h000, 1'b0, -1);
    flush();

    for (int i = 0; i < 4; i++) begin
      feed2(vecs[i]);
      drain2($sformatf("v%0d", i), vecs[i], 1'b0);
      flush();
      chk($sformatf("v%0d post-flush busy", i), {63'd0, busy2}, 64'd0);
      chk($sformatf("v%0d post-flush done", i), {63'd0, done2}, 64'd0);
    end

    feed2(vecs[0]);
    drain2("bp", vecs[0], 1'b1);
    flush();

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp8[r*8+c] = 64'(b8[r][c]);
    feed8();
    drain8("gate", 11'h040, 1'b1, -1);
    flush();

    feed8();
    drain8("abort", 11'h080, 1'b0, 2);
    for (int i = 0; i < 64; i++) exp8[i] = 64'd0;
    drain8("postflush", 11'h080, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
